// File: rtl/mem_pkg.sv
// Shared encodings for the byte-addressable data memory: access sizes, lane masks
// and the clear/idle state enum.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic {
        StClear,
        StIdle
    } state_e;

    function automatic logic [3:0] byte_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte enables and write-data merge, plus load lane
// extraction with sign/zero extension. Also decides whether an access is aligned.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        sign_ext_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] old_word_i,
    output logic        legal_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] merged_word_o,
    output logic [31:0] load_data_o
);

    logic [3:0]  be;
    logic [31:0] rep_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        legal_o  = 1'b0;
        be       = BE_NONE;
        rep_data = store_data_i;
        case (size_i)
            SZ_BYTE: begin
                legal_o  = 1'b1;
                be       = byte_mask(lane_i);
                rep_data = {4{store_data_i[7:0]}};
            end
            SZ_HALF: begin
                legal_o  = ~lane_i[0];
                be       = lane_i[1] ? BE_HI_HALF : BE_LO_HALF;
                rep_data = {2{store_data_i[15:0]}};
            end
            SZ_WORD: begin
                legal_o = (lane_i == 2'b00);
                be      = BE_WORD;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
        byte_en_o = legal_o ? be : BE_NONE;
    end

    // Replicated store data lets each lane pick its byte without a shifter.
    always_comb begin
        merged_word_o = old_word_i;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (byte_en_o[i]) begin
                merged_word_o[i*LANE_W +: LANE_W] = rep_data[i*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        byte_sel = old_word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? old_word_i[31:16] : old_word_i[15:0];
        case (size_i)
            SZ_BYTE: load_data_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
            default: load_data_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_bw.sv
// Parametrised byte-addressable data memory with byte/half/word access, registered
// load result, misalignment pulse and a sequential post-reset clear engine.
module data_mem_bw
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2     = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] INIT_VALUE     = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        memwrite_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] num_addr_i,
    input  logic [31:0] number_i,
    output logic [31:0] storage_out_o,
    output logic        busy_o,
    output logic        misalign_o
);

    localparam int unsigned Words      = 1 << DEPTH_LOG2;
    localparam state_e      ResetState = CLEAR_ON_RESET ? StClear : StIdle;

    logic [31:0] mem_q [Words];

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic [31:0]           storage_q, storage_d;
    logic                  misalign_q, misalign_d;

    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           rd_word;
    logic                  legal;
    logic [3:0]            byte_en;
    logic [31:0]           merged_word;
    logic [31:0]           load_data;
    logic                  clear_we;
    logic                  access;
    logic                  req_ok;
    logic                  store_we;
    logic                  unused_addr;

    assign word_idx    = num_addr_i[DEPTH_LOG2+1:2];
    assign lane        = num_addr_i[1:0];
    assign rd_word     = mem_q[word_idx];
    // Upper address bits are ignored so accesses wrap around the array.
    assign unused_addr = ^num_addr_i[31:DEPTH_LOG2+2];

    mem_lane_align u_lane_align (
        .size_i        (size_i),
        .lane_i        (lane),
        .sign_ext_i    (sign_ext_i),
        .store_data_i  (number_i),
        .old_word_i    (rd_word),
        .legal_o       (legal),
        .byte_en_o     (byte_en),
        .merged_word_o (merged_word),
        .load_data_o   (load_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ResetState;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: begin
                if (cnt_q == {DEPTH_LOG2{1'b1}}) begin
                    state_d = StIdle;
                end
            end
            StIdle:  state_d = StIdle;
            default: state_d = ResetState;
        endcase
    end

    always_comb begin
        busy_o   = (state_q == StClear);
        clear_we = (state_q == StClear);
        access   = (state_q == StIdle) && en_i;
        req_ok   = access && legal;
        store_we = req_ok && memwrite_i && (byte_en != BE_NONE);
    end

    always_comb begin
        cnt_d      = clear_we ? cnt_q + 1'b1 : cnt_q;
        storage_d  = storage_q;
        misalign_d = access && !legal;
        if (req_ok) begin
            // Stores return the post-write word, loads the extracted lane.
            storage_d = memwrite_i ? merged_word : load_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            storage_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            storage_q  <= storage_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (clear_we) begin
                mem_q[cnt_q] <= INIT_VALUE;
            end else if (store_we) begin
                mem_q[word_idx] <= merged_word;
            end
        end
    end

    assign storage_out_o = storage_q;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_data_mem_bw.sv
// Self-checking bench for data_mem_bw: directed vector table, clear-engine timing
// sequences, and randomized traffic against a byte-array reference model.
module tb_data_mem_bw;
    import mem_pkg::*;

    localparam int unsigned DL2    = 4;
    localparam int unsigned NBYTES = 4 << DL2;
    localparam logic [31:0] INIT   = 32'hA5A5A5A5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        memwrite_i;
    logic [1:0]  size_i;
    logic        sign_ext_i;
    logic [31:0] num_addr_i;
    logic [31:0] number_i;
    logic [31:0] storage_out_o;
    logic        busy_o;
    logic        misalign_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mbytes [NBYTES];
    logic [31:0] m_out;
    logic        m_mis;

    typedef struct {
        logic        en;
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_out;
        logic        exp_mis;
    } vec_t;

    vec_t vec [22];

    data_mem_bw #(
        .DEPTH_LOG2     (DL2),
        .CLEAR_ON_RESET (1'b1),
        .INIT_VALUE     (INIT)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .memwrite_i    (memwrite_i),
        .size_i        (size_i),
        .sign_ext_i    (sign_ext_i),
        .num_addr_i    (num_addr_i),
        .number_i      (number_i),
        .storage_out_o (storage_out_o),
        .busy_o        (busy_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < int'(NBYTES); i++) begin
            mbytes[i] = INIT[8*(i%4) +: 8];
        end
        m_out = 32'h0;
        m_mis = 1'b0;
    endtask

    // Memory viewed as a flat little-endian byte array.
    task automatic model_apply(input logic en, input logic we, input logic [1:0] sz,
                               input logic sx, input logic [31:0] a, input logic [31:0] d);
        int n;
        int base;
        int wbase;
        logic [31:0] v;
        if (!en) begin
            m_mis = 1'b0;
            return;
        end
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        base = int'(a % NBYTES);
        if (n == 0 || (base % n) != 0) begin
            m_mis = 1'b1;
            return;
        end
        m_mis = 1'b0;
        v     = 32'h0;
        if (we) begin
            for (int k = 0; k < n; k++) mbytes[base+k] = d[8*k +: 8];
            wbase = base - (base % 4);
            for (int k = 0; k < 4; k++) v[8*k +: 8] = mbytes[wbase+k];
        end else begin
            for (int k = 0; k < n; k++) v[8*k +: 8] = mbytes[base+k];
            if (sx && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        end
        m_out = v;
    endtask

    task automatic req(input logic en, input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
        en_i       = en;
        memwrite_i = we;
        size_i     = sz;
        sign_ext_i = sx;
        num_addr_i = a;
        number_i   = d;
        step();
        model_apply(en, we, sz, sx, a, d);
    endtask

    task automatic rand_inputs();
        en_i       = 1'b1;
        memwrite_i = 1'($urandom_range(0, 1));
        size_i     = 2'($urandom_range(0, 3));
        sign_ext_i = 1'($urandom_range(0, 1));
        num_addr_i = $urandom;
        number_i   = $urandom;
    endtask

    task automatic count_busy(input string tag);
        int nbusy;
        nbusy = 0;
        while (busy_o === 1'b1 && nbusy < 100) begin
            nbusy++;
            rand_inputs();
            step();
            check({tag, " clear out"}, storage_out_o, 32'h0);
            check({tag, " clear misalign"}, 32'(misalign_o), 32'h0);
        end
        en_i = 1'b0;
        check({tag, " busy cycles"}, nbusy, 32'd16);
    endtask

    task automatic rand_traffic(input int n, input string tag);
        logic we, sx, en;
        logic [1:0] sz;
        logic [31:0] a, d;
        for (int i = 0; i < n; i++) begin
            en = ($urandom_range(0, 9) != 0);
            we = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sx = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd2) ? 2'b00 : (sz == 2'd1) ? {a[1], 1'b0} : a[1:0];
            d  = $urandom;
            req(en, we, sz, sx, a, d);
            check($sformatf("%s%0d out", tag, i), storage_out_o, m_out);
            check($sformatf("%s%0d misalign", tag, i), 32'(misalign_o), 32'(m_mis));
        end
        check({tag, " busy idle"}, 32'(busy_o), 32'h0);
    endtask

    initial begin
        vec[0]  = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0,        32'hA5A5A5A5, 1'b0};
        vec[1]  = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h3C, 32'h0,        32'hA5A5A5A5, 1'b0};
        vec[2]  = '{1'b1, 1'b1, SZ_WORD, 1'b0, 32'h08, 32'h11223344, 32'h11223344, 1'b0};
        vec[3]  = '{1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h09, 32'h000000FF, 32'h1122FF44, 1'b0};
        vec[4]  = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0,        32'h1122FF44, 1'b0};
        vec[5]  = '{1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h09, 32'h0,        32'hFFFFFFFF, 1'b0};
        vec[6]  = '{1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h09, 32'h0,        32'h000000FF, 1'b0};
        vec[7]  = '{1'b1, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h00008001, 32'h8001A5A5, 1'b0};
        vec[8]  = '{1'b1, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0,        32'hFFFF8001, 1'b0};
        vec[9]  = '{1'b1, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0,        32'h00008001, 1'b0};
        vec[10] = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'h8001A5A5, 1'b0};
        vec[11] = '{1'b1, 1'b1, SZ_WORD, 1'b0, 32'h06, 32'hCAFEF00D, 32'h8001A5A5, 1'b1};
        vec[12] = '{1'b0, 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0,        32'h8001A5A5, 1'b0};
        vec[13] = '{1'b1, 1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0,        32'h8001A5A5, 1'b1};
        vec[14] = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0,        32'hA5A5A5A5, 1'b0};
        vec[15] = '{1'b1, 1'b1, SZ_RSVD, 1'b0, 32'h00, 32'h12345678, 32'hA5A5A5A5, 1'b1};
        vec[16] = '{1'b1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vec[17] = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0,        32'hDEADBEEF, 1'b0};
        vec[18] = '{1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h03, 32'h12345677, 32'h77ADBEEF, 1'b0};
        vec[19] = '{1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h03, 32'h0,        32'h00000077, 1'b0};
        vec[20] = '{1'b1, 1'b0, SZ_HALF, 1'b1, 32'h02, 32'h0,        32'h000077AD, 1'b0};
        vec[21] = '{1'b1, 1'b0, SZ_HALF, 1'b1, 32'h08, 32'h0,        32'hFFFFFF44, 1'b0};

        rst_i      = 1'b1;
        en_i       = 1'b0;
        memwrite_i = 1'b0;
        size_i     = SZ_WORD;
        sign_ext_i = 1'b0;
        num_addr_i = 32'h0;
        number_i   = 32'h0;
        step();
        step();
        check("reset storage_out", storage_out_o, 32'h0);
        check("reset misalign", 32'(misalign_o), 32'h0);
        check("reset busy", 32'(busy_o), 32'h1);
        rst_i = 1'b0;
        count_busy("boot");
        model_init();

        foreach (vec[i]) begin
            req(vec[i].en, vec[i].we, vec[i].sz, vec[i].sx, vec[i].addr, vec[i].data);
            check($sformatf("vec%0d out", i), storage_out_o, vec[i].exp_out);
            check($sformatf("vec%0d misalign", i), 32'(misalign_o), 32'(vec[i].exp_mis));
        end

        rand_traffic(300, "rnd");

        // Reset again, then pulse reset part-way through the clear.
        rst_i = 1'b1;
        en_i  = 1'b0;
        step();
        check("rst2 storage_out", storage_out_o, 32'h0);
        check("rst2 misalign", 32'(misalign_o), 32'h0);
        check("rst2 busy", 32'(busy_o), 32'h1);
        rst_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_inputs();
            step();
        end
        check("midclear busy", 32'(busy_o), 32'h1);
        check("midclear out", storage_out_o, 32'h0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        count_busy("restart");
        model_init();
        rand_traffic(80, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_bw.md
# data_mem_bw

Parametrised byte-addressable data memory for the single-cycle/pipelined MIPS datapath, successor to the fixed 1024-word store. It adds configurable depth, byte/halfword/word accesses with little-endian byte lanes, sign/zero extension on loads, a misalignment flag, and a sequential clear engine that wipes the array after reset instead of clearing it in one cycle. It sits between the ALU address output and the write-back mux.

## Interface
- DEPTH_LOG2, 10, log2 of word count; the array holds 2^DEPTH_LOG2 32-bit words.
- CLEAR_ON_RESET, 1, 1 = run the clear engine after reset; 0 = leave contents untouched.
- INIT_VALUE, 32'h0, word written to every location by the clear engine.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  access request this cycle.
- memwrite  in  1  1 = store, 0 = load; only meaningful with en=1.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- sign_ext  in  1  loads only: 1 = sign-extend byte/half, 0 = zero-extend.
- num_addr  in  32  byte address; bits [DEPTH_LOG2+1:0] are used, upper bits ignored (wrap).
- number  in  32  store data; byte stores use [7:0], half stores use [15:0].
- storage_out  out  32  registered load result.
- busy  out  1  clear engine active; requests are ignored.
- misalign  out  1  one-cycle pulse flagging a rejected access.

## Operation
- States: CLEAR, IDLE. rst=1 sampled → state CLEAR (or IDLE if CLEAR_ON_RESET=0), clear counter ← 0, storage_out ← 0, misalign ← 0.
- CLEAR: each edge with rst=0 writes INIT_VALUE to mem[cnt] and increments cnt; on the edge where cnt = 2^DEPTH_LOG2−1 the state moves to IDLE. en is ignored, storage_out holds, misalign stays 0.
- rst asserted during CLEAR restarts the counter at 0.
- IDLE, en=1: word index = num_addr[DEPTH_LOG2+1:2], lane = num_addr[1:0].
- Alignment: byte always legal; half requires num_addr[0]=0; word requires num_addr[1:0]=00; size=11 always illegal. Illegal → no array write, storage_out holds, misalign=1 next cycle.
- Store: byte writes lane num_addr[1:0] (lane 0 = bits [7:0]); half writes lanes {1,0} or {3,2}; word writes all four. Other lanes unchanged.
- Store also updates storage_out with the full post-write word (write-first; no extension).
- Load: selected byte/half is right-justified and extended per sign_ext; word passes through.
- en=0 in IDLE: storage_out holds, misalign=0, array unchanged.

## Timing
- Reset values: storage_out=0, misalign=0, busy=1 if CLEAR_ON_RESET else 0.
- busy is 1 for exactly 2^DEPTH_LOG2 edges after rst is released, then 0; the first accepted request is on the edge busy is sampled 0.
- Load latency 1: request on edge N, storage_out valid after edge N (readable in cycle N+1).
- Store visible to a load issued on the next edge (back-to-back store→load same address returns new data).
- misalign is high for exactly the one cycle following the offending request.

## Structure
- Package mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, state enum {CLEAR, IDLE}, lane helper constants.
- One sub-module: mem_lane_align — combinational byte-enable generation for stores and lane extract + sign/zero extension for loads; the top holds the array, FSM, counter and output registers.

## Test plan
- Reset with DEPTH_LOG2=4, INIT_VALUE=32'hA5A5A5A5 → busy high exactly 16 cycles; then word loads of addr 0x0 and 0x3C return 0xA5A5A5A5.
- Word store 0x11223344 to 0x8, then byte store 0xFF to 0x9 → word load 0x8 returns 0x1122FF44; lb 0x9 sign_ext=1 → 0xFFFFFFFF; lbu → 0x000000FF.
- Half store 0x8001 to 0x12 → lh 0x12 = 0xFFFF8001, lhu = 0x00008001, word load 0x10 shows upper half 0x8001.
- Word store to 0x6 and half load from 0x3 → misalign=1 one cycle each, storage_out unchanged, location 0x4 unmodified.
- rst pulsed mid-clear (cycle 7 of 16) → busy remains high 16 further cycles; requests with en=1 during busy have no effect.
- Address 0x40 with DEPTH_LOG2=4 aliases to 0x0: store 0xDEADBEEF to 0x40, load 0x0 returns 0xDEADBEEF.
